// File: rtl/op_fetch.sv
// Opcode fetch unit: reads opcode bytes from memory, merges CB-prefixed pairs
// into one extended op and holds each op until the core accepts it.
//
// state     | meaning
// IDLE      | just out of reset; first read request issued on the next cycle
// FETCH     | reading the first byte of an op (plain opcode or prefix)
// FETCH_EXT | prefix seen; reading the extended opcode byte
// HOLD      | op presented on op/ext/op_pc, waiting for op_ready
module op_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic [7:0]  op,
  output logic        ext,
  output logic [15:0] op_pc,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_in
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    FETCH_EXT = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  op_q, op_d;
  logic        ext_q, ext_d;
  logic [15:0] op_pc_q, op_pc_d;
  logic        op_valid_q, op_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      op_q       <= 8'h00;
      ext_q      <= 1'b0;
      op_pc_q    <= 16'h0000;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      ext_q      <= ext_d;
      op_pc_q    <= op_pc_d;
      op_valid_q <= op_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    ext_d      = ext_q;
    op_pc_d    = op_pc_q;
    op_valid_d = op_valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (pc_load) pc_d = pc_in;
      end

      FETCH: begin
        // A redirect wins over a read completing on the same edge.
        if (pc_load) begin
          pc_d       = pc_in;
          op_valid_d = 1'b0;
          ext_d      = 1'b0;
          state_d    = FETCH;
        end else if (mem_ready) begin
          op_pc_d = pc_q;
          pc_d    = pc_q + 16'd1;
          if (mem_data == CB_PREFIX) begin
            state_d = FETCH_EXT;
          end else begin
            op_d       = mem_data;
            ext_d      = 1'b0;
            op_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
      end

      FETCH_EXT: begin
        if (pc_load) begin
          pc_d       = pc_in;
          op_valid_d = 1'b0;
          ext_d      = 1'b0;
          state_d    = FETCH;
        end else if (mem_ready) begin
          // op_pc_q still points at the prefix byte.
          op_d       = mem_data;
          ext_d      = 1'b1;
          op_valid_d = 1'b1;
          pc_d       = pc_q + 16'd1;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        if (pc_load) begin
          pc_d       = pc_in;
          op_valid_d = 1'b0;
          ext_d      = 1'b0;
          state_d    = FETCH;
        end else if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_rd   = (state_q == FETCH) || (state_q == FETCH_EXT);
  assign mem_addr = pc_q;
  assign op       = op_q;
  assign ext      = ext_q;
  assign op_pc    = op_pc_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_op_fetch.sv
// Bench for op_fetch: directed scenarios plus randomized redirects and
// handshakes, checked by a scoreboard fed from a byte-stream decoder model.
module tb_op_fetch;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [7:0]  CB_PREFIX = 8'hCB;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic [7:0]  op;
  logic        ext;
  logic [15:0] op_pc;
  logic        op_valid;
  logic        op_ready;
  logic        pc_load;
  logic [15:0] pc_in;

  logic [7:0] mem [0:65535];
  assign mem_data = mem[mem_addr];

  typedef struct {
    logic [7:0]  op;
    logic        ext;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  op_fetch #(
    .RESET_PC  (RESET_PC),
    .CB_PREFIX (CB_PREFIX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .op        (op),
    .ext       (ext),
    .op_pc     (op_pc),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .pc_load   (pc_load),
    .pc_in     (pc_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ops the core should see, decoded straight from memory starting at start.
  function automatic void load_stream(input logic [15:0] start);
    logic [15:0] a;
    exp_t e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      if (mem[a] == CB_PREFIX) begin
        e.op  = mem[16'(a + 16'd1)];
        e.ext = 1'b1;
        e.pc  = a;
        a     = a + 16'd2;
      end else begin
        e.op  = mem[a];
        e.ext = 1'b0;
        e.pc  = a;
        a     = a + 16'd1;
      end
      exp_q.push_back(e);
    end
  endfunction

  // Inputs change and outputs are checked 2 time units after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitor: samples mid-cycle, i.e. the values the next rising edge will act on.
  exp_t        e_mon;
  int          idle_cnt = 0;
  logic        prev_hold = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_op;
  logic [15:0] prev_addr;

  always @(negedge clk) begin
    if (rst) begin
      if (prev_hold) begin
        chk("held op_valid", 32'(op_valid), 32'd1);
        chk("held op", 32'(op), 32'(prev_op));
      end
      if (prev_stall) begin
        chk("stalled mem_rd", 32'(mem_rd), 32'd1);
        chk("stalled mem_addr", 32'(mem_addr), 32'(prev_addr));
      end
      chk("mem_rd with op_valid", 32'(mem_rd & op_valid), 32'd0);
      if (op_valid && op_ready && !pc_load) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected op: got op=%h ext=%b op_pc=%h, expected none", op, ext, op_pc);
        end else begin
          e_mon = exp_q.pop_front();
          chk("scoreboard op", 32'(op), 32'(e_mon.op));
          chk("scoreboard ext", 32'(ext), 32'(e_mon.ext));
          chk("scoreboard op_pc", 32'(op_pc), 32'(e_mon.pc));
        end
        idle_cnt = 0;
      end else if (pc_load) begin
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
      if (idle_cnt > 100) begin
        chk("progress watchdog cycles", 32'(idle_cnt), 32'd0);
        idle_cnt = 0;
      end
      prev_hold  = op_valid && !op_ready && !pc_load;
      prev_stall = mem_rd && !mem_ready && !pc_load;
      prev_op    = op;
      prev_addr  = mem_addr;
    end else begin
      prev_hold  = 1'b0;
      prev_stall = 1'b0;
      idle_cnt   = 0;
    end
  end

  task automatic chk_op(input string tag, input logic [7:0] o, input logic x, input logic [15:0] p);
    chk({tag, " op_valid"}, 32'(op_valid), 32'd1);
    chk({tag, " op"}, 32'(op), 32'(o));
    chk({tag, " ext"}, 32'(ext), 32'(x));
    chk({tag, " op_pc"}, 32'(op_pc), 32'(p));
  endtask

  task automatic redirect(input logic [15:0] a);
    pc_load = 1'b1;
    pc_in   = a;
    load_stream(a);
    cyc();
    pc_load = 1'b0;
  endtask

  initial begin
    logic [15:0] base;
    int          len;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst       = 1'b0;
    mem_ready = 1'b1;
    op_ready  = 1'b1;
    pc_load   = 1'b0;
    pc_in     = 16'h0000;
    mem[16'h0000] = 8'h3E;
    mem[16'h0001] = 8'h06;
    mem[16'h0002] = 8'h00;

    // Reset values and the two-op sequence from address 0.
    cyc();
    cyc();
    chk("reset mem_rd", 32'(mem_rd), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'(RESET_PC));
    chk("reset op_valid", 32'(op_valid), 32'd0);
    chk("reset op", 32'(op), 32'h00);
    chk("reset ext", 32'(ext), 32'd0);
    chk("reset op_pc", 32'(op_pc), 32'h0000);
    rst = 1'b1;
    load_stream(RESET_PC);
    chk("idle mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    chk("first fetch mem_rd", 32'(mem_rd), 32'd1);
    chk("first fetch addr", 32'(mem_addr), 32'h0000);
    chk("first fetch op_valid", 32'(op_valid), 32'd0);
    cyc();
    chk_op("op 3E", 8'h3E, 1'b0, 16'h0000);
    chk("hold mem_rd", 32'(mem_rd), 32'd0);
    chk("addr after 3E", 32'(mem_addr), 32'h0001);
    cyc();
    chk("refetch mem_rd", 32'(mem_rd), 32'd1);
    chk("refetch addr", 32'(mem_addr), 32'h0001);
    cyc();
    chk_op("op 06", 8'h06, 1'b0, 16'h0001);
    chk("addr after 06", 32'(mem_addr), 32'h0002);

    // Core back-pressure: op held for 5 cycles.
    rst = 1'b0;
    exp_q.delete();
    cyc();
    rst = 1'b1;
    op_ready = 1'b0;
    load_stream(RESET_PC);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk_op("backpressure", 8'h3E, 1'b0, 16'h0000);
      chk("backpressure mem_rd", 32'(mem_rd), 32'd0);
      chk("backpressure addr", 32'(mem_addr), 32'h0001);
      if (i < 4) cyc();
    end
    op_ready = 1'b1;
    cyc();
    chk("release op_valid", 32'(op_valid), 32'd0);
    chk("release mem_rd", 32'(mem_rd), 32'd1);
    cyc();
    chk_op("op 06 again", 8'h06, 1'b0, 16'h0001);

    // Memory wait states: 3 cycles stalled in FETCH.
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("wait mem_rd", 32'(mem_rd), 32'd1);
      chk("wait addr", 32'(mem_addr), 32'h0002);
      chk("wait op_valid", 32'(op_valid), 32'd0);
      if (i < 2) cyc();
    end
    mem_ready = 1'b1;
    cyc();
    chk_op("after wait", 8'h00, 1'b0, 16'h0002);

    // Prefixed op at 0010.
    mem[16'h0010] = 8'hCB;
    mem[16'h0011] = 8'h37;
    mem[16'h0012] = 8'h00;
    redirect(16'h0010);
    chk("cb fetch addr", 32'(mem_addr), 32'h0010);
    chk("cb fetch op_valid", 32'(op_valid), 32'd0);
    cyc();
    chk("cb ext addr", 32'(mem_addr), 32'h0011);
    chk("cb ext mem_rd", 32'(mem_rd), 32'd1);
    chk("prefix not delivered", 32'(op_valid), 32'd0);
    cyc();
    chk_op("cb 37", 8'h37, 1'b1, 16'h0010);
    chk("addr after cb 37", 32'(mem_addr), 32'h0012);

    // Redirect on a completing read, then on a pending transfer.
    mem[16'h0020] = 8'h5A;
    mem[16'h1234] = 8'h42;
    redirect(16'h0020);
    chk("pre-discard addr", 32'(mem_addr), 32'h0020);
    redirect(16'h1234);
    chk("discard op_valid", 32'(op_valid), 32'd0);
    chk("discard addr", 32'(mem_addr), 32'h1234);
    chk("discard mem_rd", 32'(mem_rd), 32'd1);
    chk("discard op kept", 32'(op), 32'h37);
    chk("discard ext cleared", 32'(ext), 32'd0);
    cyc();
    chk_op("op 42", 8'h42, 1'b0, 16'h1234);
    redirect(16'h2000);
    chk("transfer discard op_valid", 32'(op_valid), 32'd0);
    chk("transfer discard addr", 32'(mem_addr), 32'h2000);

    // Prefix at FFFF wrapping to 0000, then reset while holding.
    mem[16'hFFFF] = 8'hCB;
    mem[16'h0000] = 8'h11;
    mem[16'h0001] = 8'h22;
    redirect(16'hFFFF);
    chk("wrap fetch addr", 32'(mem_addr), 32'hFFFF);
    cyc();
    chk("wrap ext addr", 32'(mem_addr), 32'h0000);
    chk("wrap prefix op_valid", 32'(op_valid), 32'd0);
    cyc();
    chk_op("wrap 11", 8'h11, 1'b1, 16'hFFFF);
    chk("wrap next addr", 32'(mem_addr), 32'h0001);
    op_ready = 1'b0;
    cyc();
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async reset op_valid", 32'(op_valid), 32'd0);
    chk("async reset mem_rd", 32'(mem_rd), 32'd0);
    chk("async reset addr", 32'(mem_addr), 32'(RESET_PC));
    chk("async reset op", 32'(op), 32'h00);
    chk("async reset ext", 32'(ext), 32'd0);
    cyc();
    rst = 1'b1;
    op_ready = 1'b1;
    load_stream(RESET_PC);
    chk("post-reset idle mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    chk("post-reset mem_rd", 32'(mem_rd), 32'd1);
    chk("post-reset addr", 32'(mem_addr), 32'(RESET_PC));
    cyc();
    chk_op("post-reset op", 8'h11, 1'b0, 16'h0000);

    // Randomized segments: fresh code window, redirect, random handshakes.
    for (int seg = 0; seg < 60; seg++) begin
      base = 16'($urandom);
      for (int i = 0; i < 160; i++)
        mem[16'(base + 16'(i))] = ($urandom_range(0, 3) == 0) ? CB_PREFIX : 8'($urandom);
      redirect(base);
      len = int'($urandom_range(10, 60));
      for (int k = 0; k < len; k++) begin
        mem_ready = ($urandom_range(0, 9) < 7);
        op_ready  = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 79) == 0) begin
          rst = 1'b0;
          exp_q.delete();
          cyc();
          rst = 1'b1;
          load_stream(RESET_PC);
        end
        cyc();
      end
    end

    mem_ready = 1'b1;
    op_ready  = 1'b1;
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/op_fetch.md
OP_FETCH -- requirements
Module: op_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the fetch address loaded by reset.
REQ-002 The block SHALL have parameter CB_PREFIX, default 8'hCB, meaning the extended-opcode prefix byte.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-low.
- mem_rd  output  1  memory read request.
- mem_addr  output  16  memory read address.
- mem_data  input  8  read data, valid when mem_ready=1.
- mem_ready  input  1  read completes on the rising edge where mem_rd=1 and mem_ready=1.
- op  output  8  opcode byte delivered to the core (the byte after the prefix for extended ops).
- ext  output  1  op is from the CB-prefixed (extended) table.
- op_pc  output  16  address of the first byte (prefix included) of the delivered op.
- op_valid  output  1  op, ext and op_pc are valid.
- op_ready  input  1  core accepts op; transfer occurs on the edge where op_valid=1 and op_ready=1.
- pc_load  input  1  redirect fetch (jump, call, return, interrupt).
- pc_in  input  16  new fetch address, sampled when pc_load=1.

Function
REQ-004 The block SHALL implement the FSM states IDLE, FETCH, FETCH_EXT and HOLD.
REQ-005 The block SHALL hold an internal 16-bit pc register; mem_addr SHALL equal pc combinationally.
REQ-006 mem_rd SHALL be 1 exactly in FETCH and FETCH_EXT, and 0 in IDLE and HOLD.
REQ-007 IDLE SHALL unconditionally go to FETCH on the next edge.
REQ-008 FETCH, on a completed read:
- if mem_data != CB_PREFIX: capture mem_data into op, set ext=0, set op_valid=1, go to HOLD.
- if mem_data == CB_PREFIX: go to FETCH_EXT with op_valid unchanged at 0.
- in both cases: latch op_pc=pc and set pc<=pc+1.
REQ-009 FETCH_EXT, on a completed read, SHALL capture mem_data into op, set ext=1, set op_valid=1, set pc<=pc+1 and go to HOLD; op_pc SHALL keep the prefix address.
REQ-010 In FETCH_EXT, a CB_PREFIX data byte SHALL be treated as an ordinary extended opcode (op=8'hCB, ext=1).
REQ-011 While mem_ready=0 in FETCH or FETCH_EXT, the state, pc and mem_addr SHALL be held and mem_rd SHALL stay 1.
REQ-012 In HOLD, op, ext, op_pc and op_valid=1 SHALL be held stable until a transfer; on the transfer edge op_valid<=0 and the FSM SHALL go to FETCH.
REQ-013 Best-case latency: a non-prefixed op SHALL be delivered with op_valid=1 one cycle after its read completes; back-to-back, one op per 2 cycles.
REQ-014 pc SHALL increment modulo 2^16 (16'hFFFF+1 = 16'h0000), including between a prefix byte and its extended byte.
REQ-015 pc_load SHALL have highest priority in every state except IDLE: on that edge pc<=pc_in, op_valid<=0, ext<=0 and the FSM SHALL go to FETCH.
REQ-016 On a pc_load edge, a read completing on the same edge and a pending transfer SHALL both be discarded (no op capture, no pc increment).
REQ-017 pc_load in IDLE SHALL load pc<=pc_in and go to FETCH.
REQ-018 op and op_pc SHALL only change on the capture edges defined in REQ-008 and REQ-009.

Reset
REQ-019 While rst=0, asynchronously:
- state=IDLE, pc=RESET_PC
- op=8'h00, ext=0, op_pc=16'h0000, op_valid=0
- mem_rd=0, mem_addr=RESET_PC
REQ-020 Reset asserted mid-fetch or in HOLD SHALL abandon the read or held op with no further output activity, and the first mem_rd after release SHALL occur one cycle after the first edge (IDLE->FETCH).

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Reset then memory {0000:3E, 0001:06}, mem_ready=1, op_ready=1 -> op=3E ext=0 op_pc=0000, then op=06 op_pc=0001; mem_addr 0000,0001,0002.
- Memory {0010:CB, 0011:37}, pc_load=1 pc_in=0010 -> single op=37 ext=1 op_pc=0010; next fetch address 0012; op_valid never high for the CB byte.
- op_ready=0 for 5 cycles after op=3E valid -> op/op_valid held 5 cycles, mem_rd=0 throughout, mem_addr unchanged.
- mem_ready=0 for 3 cycles in FETCH -> mem_rd=1 and mem_addr constant for 3 cycles, no op_valid.
- pc_load (pc_in=1234) asserted on the same edge as a mem_ready completion and a transfer -> op_valid=0 next cycle, next mem_addr=1234, discarded byte never appears on op.
- CB at FFFF, 11 at 0000 -> op=11 ext=1 op_pc=FFFF, next mem_addr=0001; rst pulsed low while in HOLD -> op_valid=0 immediately, refetch from RESET_PC.
